// File: rtl/gate_control_pq.sv
// Output-port gate controller: fetches a GCL entry per Qbv slot switch from external RAM, or derives gates from slot parity in Qch.
// Optional build macro GC_OVERRUN_CNT_EN adds the saturating lost-switch counter port ov_overrun_cnt.
module gate_control_pq #(
    parameter int QUEUE_NUM   = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int RAM_LATENCY = 2,
    parameter int QCH_QUEUE_A = 0,
    parameter int QCH_QUEUE_B = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_qbv_or_qch,
    input  logic [ADDR_WIDTH-1:0] iv_time_slot,
    input  logic                  i_time_slot_switch,
    input  logic [QUEUE_NUM-1:0]  iv_ram_rdata,
    output logic [ADDR_WIDTH-1:0] ov_ram_raddr,
    output logic                  o_ram_rd,
    output logic [1:0]            ov_in_gate_ctrl_vector,
    output logic [QUEUE_NUM-1:0]  ov_out_gate_ctrl_vector,
    output logic                  o_gate_update
`ifdef GC_OVERRUN_CNT_EN
    ,
    output logic [15:0]           ov_overrun_cnt
`endif
);

    localparam int CNT_W = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT, LOAD} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] latched_q, latched_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  rd_q, rd_d;
    logic [1:0]            in_gate_q, in_gate_d;
    logic [QUEUE_NUM-1:0]  out_vec_q, out_vec_d;
    logic                  upd_q, upd_d;
    logic [QUEUE_NUM-1:0]  qch_vec;

    always_comb begin
        qch_vec = '1;
        if (iv_time_slot[0])
            qch_vec[QCH_QUEUE_B] = 1'b0;
        else
            qch_vec[QCH_QUEUE_A] = 1'b0;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        latched_d = latched_q;
        raddr_d   = raddr_q;
        rd_d      = 1'b0;
        out_vec_d = out_vec_q;
        upd_d     = 1'b0;
        in_gate_d = i_qbv_or_qch ? (iv_time_slot[0] ? 2'b10 : 2'b01) : 2'b11;

        if (i_qbv_or_qch) begin
            // Qch overrides everything and drops any read still in flight
            state_d   = IDLE;
            pending_d = 1'b0;
            out_vec_d = qch_vec;
            upd_d     = (qch_vec != out_vec_q);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_time_slot_switch) begin
                        raddr_d   = iv_time_slot;
                        rd_d      = 1'b1;
                        pending_d = 1'b0;
                        state_d   = READ;
                    end else if (pending_q) begin
                        raddr_d   = latched_q;
                        rd_d      = 1'b1;
                        pending_d = 1'b0;
                        state_d   = READ;
                    end
                end
                READ: begin
                    cnt_d   = CNT_W'(RAM_LATENCY - 1);
                    state_d = (RAM_LATENCY == 1) ? LOAD : WAIT;
                    if (i_time_slot_switch) begin
                        pending_d = 1'b1;
                        latched_d = iv_time_slot;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1))
                        state_d = LOAD;
                    else
                        cnt_d = cnt_q - CNT_W'(1);
                    if (i_time_slot_switch) begin
                        pending_d = 1'b1;
                        latched_d = iv_time_slot;
                    end
                end
                LOAD: begin
                    out_vec_d = iv_ram_rdata;
                    upd_d     = 1'b1;
                    if (pending_q) begin
                        raddr_d   = latched_q;
                        rd_d      = 1'b1;
                        pending_d = 1'b0;
                        state_d   = READ;
                    end else begin
                        state_d = IDLE;
                    end
                    // A switch here queues behind the read just issued
                    if (i_time_slot_switch) begin
                        pending_d = 1'b1;
                        latched_d = iv_time_slot;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            latched_q <= '0;
            raddr_q   <= '0;
            rd_q      <= 1'b0;
            in_gate_q <= 2'b00;
            out_vec_q <= '0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            latched_q <= latched_d;
            raddr_q   <= raddr_d;
            rd_q      <= rd_d;
            in_gate_q <= in_gate_d;
            out_vec_q <= out_vec_d;
            upd_q     <= upd_d;
        end
    end

`ifdef GC_OVERRUN_CNT_EN
    logic        overrun;
    logic [15:0] ovr_q, ovr_d;

    // A switch lands on an unconsumed pending slot (LOAD consumes it in the same cycle)
    assign overrun = !i_qbv_or_qch && i_time_slot_switch && pending_q && (state_q != LOAD);

    always_comb begin
        ovr_d = ovr_q;
        if (overrun && (ovr_q != 16'hFFFF))
            ovr_d = ovr_q + 16'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            ovr_q <= 16'd0;
        else
            ovr_q <= ovr_d;
    end

    assign ov_overrun_cnt = ovr_q;
`endif

    assign ov_ram_raddr            = raddr_q;
    assign o_ram_rd                = rd_q;
    assign ov_in_gate_ctrl_vector  = in_gate_q;
    assign ov_out_gate_ctrl_vector = out_vec_q;
    assign o_gate_update           = upd_q;

endmodule

// File: tb/tb_gate_control_pq.sv
// Directed bench for gate_control_pq: three instances (RAM latency 1, 2, 4) share one stimulus stream.
module tb_gate_control_pq;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [9:0] slot;
    logic       sw;

    logic [9:0] a1, a2, a4;
    logic       rd1, rd2, rd4;
    logic [1:0] ig1, ig2, ig4;
    logic [7:0] og1, og2, og4;
    logic       up1, up2, up4;
    logic [7:0] p1 [0:0];
    logic [7:0] p2 [0:1];
    logic [7:0] p4 [0:3];
`ifdef GC_OVERRUN_CNT_EN
    logic [15:0] ov1, ov2, ov4;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int rdcnt = 0;
    int rd_base;

    always #4 clk = ~clk;

    function automatic logic [7:0] ramf(input logic [9:0] a);
        return a[7:0] ^ 8'hA0;
    endfunction

    // RAM models: data for a read strobed at edge E is present after edge E+L-1
    always @(posedge clk) begin
        p1[0] <= rd1 ? ramf(a1) : 8'h00;
        p2[0] <= rd2 ? ramf(a2) : 8'h00;
        p2[1] <= p2[0];
        p4[0] <= rd4 ? ramf(a4) : 8'h00;
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
        if (rd2) rdcnt <= rdcnt + 1;
    end

    gate_control_pq #(.RAM_LATENCY(1)) u_l1 (
        .i_clk(clk), .i_rst(rst), .i_qbv_or_qch(mode), .iv_time_slot(slot),
        .i_time_slot_switch(sw), .iv_ram_rdata(p1[0]), .ov_ram_raddr(a1), .o_ram_rd(rd1),
        .ov_in_gate_ctrl_vector(ig1), .ov_out_gate_ctrl_vector(og1), .o_gate_update(up1)
`ifdef GC_OVERRUN_CNT_EN
        , .ov_overrun_cnt(ov1)
`endif
    );

    gate_control_pq #(.RAM_LATENCY(2)) u_l2 (
        .i_clk(clk), .i_rst(rst), .i_qbv_or_qch(mode), .iv_time_slot(slot),
        .i_time_slot_switch(sw), .iv_ram_rdata(p2[1]), .ov_ram_raddr(a2), .o_ram_rd(rd2),
        .ov_in_gate_ctrl_vector(ig2), .ov_out_gate_ctrl_vector(og2), .o_gate_update(up2)
`ifdef GC_OVERRUN_CNT_EN
        , .ov_overrun_cnt(ov2)
`endif
    );

    gate_control_pq #(.RAM_LATENCY(4)) u_l4 (
        .i_clk(clk), .i_rst(rst), .i_qbv_or_qch(mode), .iv_time_slot(slot),
        .i_time_slot_switch(sw), .iv_ram_rdata(p4[3]), .ov_ram_raddr(a4), .o_ram_rd(rd4),
        .ov_in_gate_ctrl_vector(ig4), .ov_out_gate_ctrl_vector(og4), .o_gate_update(up4)
`ifdef GC_OVERRUN_CNT_EN
        , .ov_overrun_cnt(ov4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; slot = 10'd0; sw = 1'b0;
        tick(); tick();
        chk("rst_out", 32'(og2), 32'h00);
        chk("rst_in", 32'(ig2), 32'h0);
        chk("rst_rd", 32'(rd2), 32'h0);
        chk("rst_raddr", 32'(a2), 32'h0);
        chk("rst_upd", 32'(up2), 32'h0);
`ifdef GC_OVERRUN_CNT_EN
        chk("rst_ovr", 32'(ov2), 32'h0);
`endif
        rst = 1'b0;
        tick();
        chk("qbv_in_gate", 32'(ig2), 32'h3);

        // single switch, slot 5, sampled at edge T
        slot = 10'd5; sw = 1'b1;
        tick();                                   // cycle T+1
        sw = 1'b0;
        chk("t1_rd", 32'(rd2), 32'h1);
        chk("t1_raddr", 32'(a2), 32'h5);
        tick();                                   // T+2
        chk("t1_rd_low", 32'(rd2), 32'h0);
        chk("l1_upd_early", 32'(up1), 32'h0);
        tick();                                   // T+3
        chk("l1_out", 32'(og1), 32'hA5);
        chk("l1_upd", 32'(up1), 32'h1);
        chk("t1_upd_early", 32'(up2), 32'h0);
        chk("t1_out_early", 32'(og2), 32'h00);
        tick();                                   // T+4
        chk("t1_out", 32'(og2), 32'hA5);
        chk("t1_upd", 32'(up2), 32'h1);
        chk("t1_in", 32'(ig2), 32'h3);
        tick();                                   // T+5
        chk("t1_upd_pulse", 32'(up2), 32'h0);
        chk("l4_upd_early", 32'(up4), 32'h0);
        tick();                                   // T+6
        chk("l4_out", 32'(og4), 32'hA5);
        chk("l4_upd", 32'(up4), 32'h1);
        tick(); tick(); tick();

        // slot 3, then slot 4 two cycles later
        rd_base = rdcnt;
        slot = 10'd3; sw = 1'b1;
        tick();                                   // T+1
        sw = 1'b0;
        chk("t2_raddr0", 32'(a2), 32'h3);
        tick();                                   // T+2
        slot = 10'd4; sw = 1'b1;
        tick();                                   // T+3
        sw = 1'b0;
        chk("t2_no_rd", 32'(rd2), 32'h0);
        tick();                                   // T+4
        chk("t2_out0", 32'(og2), 32'hA3);
        chk("t2_rd1", 32'(rd2), 32'h1);
        chk("t2_raddr1", 32'(a2), 32'h4);
        tick(); tick();                           // T+6
        chk("t2_out_hold", 32'(og2), 32'hA3);
        tick();                                   // T+7
        chk("t2_out1", 32'(og2), 32'hA4);
        chk("t2_upd1", 32'(up2), 32'h1);
        tick(); tick(); tick();
        chk("t2_reads", 32'(rdcnt - rd_base), 32'd2);

        // slots 3, 4, 7 inside one read window
        rd_base = rdcnt;
        slot = 10'd3; sw = 1'b1;
        tick();
        chk("t3_raddr0", 32'(a2), 32'h3);
        slot = 10'd4;
        tick();
        slot = 10'd7;
        tick();
        sw = 1'b0;
        tick();
        chk("t3_out0", 32'(og2), 32'hA3);
        chk("t3_raddr1", 32'(a2), 32'h7);
        tick(); tick(); tick();
        chk("t3_out1", 32'(og2), 32'hA7);
        tick(); tick(); tick(); tick();
        chk("t3_reads", 32'(rdcnt - rd_base), 32'd2);
`ifdef GC_OVERRUN_CNT_EN
        chk("t3_overrun", 32'(ov2), 32'd1);
`endif

        // Qch parity gating
        rd_base = rdcnt;
        mode = 1'b1; slot = 10'd2;
        tick();
        chk("qch_even_out", 32'(og2), 32'hFE);
        chk("qch_even_in", 32'(ig2), 32'h1);
        chk("qch_even_upd", 32'(up2), 32'h1);
        tick();
        chk("qch_same_upd", 32'(up2), 32'h0);
        slot = 10'd3;
        tick();
        chk("qch_odd_out", 32'(og2), 32'hFD);
        chk("qch_odd_in", 32'(ig2), 32'h2);
        chk("qch_odd_upd", 32'(up2), 32'h1);
        tick();
        chk("qch_no_rd", 32'(rdcnt - rd_base), 32'd0);

        // back to Qbv: vector holds without a switch
        mode = 1'b0;
        tick(); tick(); tick();
        chk("qbv_hold_out", 32'(og2), 32'hFD);
        chk("qbv_hold_rd", 32'(rdcnt - rd_base), 32'd0);

        // Qch raised while a read is in WAIT
        slot = 10'd5; sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("ab_rd", 32'(rd2), 32'h1);
        tick();                                   // now in WAIT
        mode = 1'b1; slot = 10'd4;
        tick();
        chk("ab_out", 32'(og2), 32'hFE);
        chk("ab_upd", 32'(up2), 32'h1);
        chk("ab_in", 32'(ig2), 32'h1);
        mode = 1'b0;
        tick();
        chk("ab_no_load_out", 32'(og2), 32'hFE);
        chk("ab_no_load_upd", 32'(up2), 32'h0);
        tick(); tick();
        chk("ab_out_hold", 32'(og2), 32'hFE);

        // reset mid-read
        slot = 10'd6; sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("mr_raddr", 32'(a2), 32'h6);
        tick();
        rst = 1'b1;
        tick();
        chk("mr_out", 32'(og2), 32'h00);
        chk("mr_in", 32'(ig2), 32'h0);
        chk("mr_rd", 32'(rd2), 32'h0);
        chk("mr_raddr0", 32'(a2), 32'h0);
        chk("mr_upd", 32'(up2), 32'h0);
`ifdef GC_OVERRUN_CNT_EN
        chk("mr_ovr", 32'(ov2), 32'h0);
`endif
        rst = 1'b0;
        tick(); tick(); tick();
        chk("mr_late_out", 32'(og2), 32'h00);
        chk("mr_late_upd", 32'(up2), 32'h0);
        chk("mr_in_qbv", 32'(ig2), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
